// File: rtl/mem_stage_access.sv
// rtl/mem_stage_access.sv - MEM pipeline stage: ALU pass-through and data-memory load/store access
//
// Purpose: produces the MEM-side inputs of the MEM->WB register. Non-memory
// instructions pass straight through in the same cycle. Loads and stores run
// one req/ack transaction per op (IDLE -> REQ -> DONE) and stall upstream
// until done. Illegal or misaligned ops raise a fault pulse and never reach the bus.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   EX_*                  EX/MEM register contents (valid, alu_out/address,
//                         store data, rd, we, load/store flags, funct3)
//   dmem_req/we/addr/     registered data-memory bus request, held until ack
//   wdata/wstrb
//   dmem_ack, dmem_rdata  bus completion and read data
//   MEM_data_mem/rd/we    result, destination and write enable to WB
//   MEM_stall             hold PC/IF/ID/EX registers
//   MEM_misaligned        fault pulse for illegal or misaligned access
module mem_stage_access #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_valid,
  input  logic [XLEN-1:0]   EX_alu_out,
  input  logic [XLEN-1:0]   EX_store_data,
  input  logic [4:0]        EX_rd,
  input  logic              EX_we,
  input  logic              EX_mem_rd,
  input  logic              EX_mem_wr,
  input  logic [2:0]        EX_funct3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [STRB_W-1:0] dmem_wstrb,
  input  logic              dmem_ack,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   MEM_data_mem,
  output logic [4:0]        MEM_rd,
  output logic              MEM_we,
  output logic              MEM_stall,
  output logic              MEM_misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_q, we_d;
  logic              is_load_q, is_load_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [STRB_W-1:0] dmem_wstrb_q, dmem_wstrb_d;

  logic              mem_op, f3_legal, misaligned, fault;
  logic [XLEN-1:0]   st_wdata, ld_ext;
  logic [STRB_W-1:0] st_wstrb;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;

  assign mem_op = EX_valid & (EX_mem_rd | EX_mem_wr);

  // Legality and alignment of the op currently presented by EX.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    if (EX_mem_rd && !EX_mem_wr) begin
      f3_legal = (EX_funct3 == 3'b000) || (EX_funct3 == 3'b001) || (EX_funct3 == 3'b010) ||
                 (EX_funct3 == 3'b100) || (EX_funct3 == 3'b101);
    end else if (EX_mem_wr && !EX_mem_rd) begin
      f3_legal = (EX_funct3 == 3'b000) || (EX_funct3 == 3'b001) || (EX_funct3 == 3'b010);
    end
    case (EX_funct3[1:0])
      2'b01:   misaligned = EX_alu_out[0];
      2'b10:   misaligned = |EX_alu_out[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign fault = mem_op & (~f3_legal | misaligned);

  // Store data is replicated across lanes; the strobe picks the lane(s).
  always_comb begin
    st_wdata = EX_store_data;
    st_wstrb = '0;
    if (EX_mem_wr) begin
      case (EX_funct3[1:0])
        2'b00: begin
          st_wdata = {4{EX_store_data[7:0]}};
          st_wstrb = 4'b0001 << EX_alu_out[1:0];
        end
        2'b01: begin
          st_wdata = {2{EX_store_data[15:0]}};
          st_wstrb = 4'b0011 << EX_alu_out[1:0];
        end
        default: st_wstrb = 4'b1111;
      endcase
    end
  end

  // Load lane extraction from the captured read word.
  always_comb begin
    ld_byte = rdata_q[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    addr_lo_d      = addr_lo_q;
    funct3_d       = funct3_q;
    rd_d           = rd_q;
    we_d           = we_q;
    is_load_d      = is_load_q;
    rdata_d        = rdata_q;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_wstrb_d   = dmem_wstrb_q;
    MEM_data_mem   = '0;
    MEM_rd         = '0;
    MEM_we         = 1'b0;
    MEM_stall      = 1'b0;
    MEM_misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mem_op) begin
          MEM_data_mem = EX_valid ? EX_alu_out : '0;
          MEM_rd       = EX_valid ? EX_rd : 5'd0;
          MEM_we       = EX_valid & EX_we;
        end else if (fault) begin
          MEM_misaligned = 1'b1;
        end else begin
          MEM_stall    = 1'b1;
          addr_lo_d    = EX_alu_out[1:0];
          funct3_d     = EX_funct3;
          rd_d         = EX_rd;
          we_d         = EX_we;
          is_load_d    = EX_mem_rd;
          dmem_req_d   = 1'b1;
          dmem_we_d    = EX_mem_wr;
          dmem_addr_d  = {EX_alu_out[XLEN-1:2], 2'b00};
          dmem_wdata_d = st_wdata;
          dmem_wstrb_d = st_wstrb;
          state_d      = REQ;
        end
      end
      REQ: begin
        MEM_stall = 1'b1;
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (is_load_q) rdata_d = dmem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        // EX still shows the op just completed; it is re-evaluated from IDLE.
        MEM_rd = rd_q;
        if (is_load_q) begin
          MEM_we       = we_q;
          MEM_data_mem = ld_ext;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_lo_q    <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      is_load_q    <= 1'b0;
      rdata_q      <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      we_q         <= we_d;
      is_load_q    <= is_load_d;
      rdata_q      <= rdata_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_wstrb_q <= dmem_wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// tb/tb_mem_stage_access.sv - directed self-checking bench for mem_stage_access
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_valid;
  logic [31:0] EX_alu_out;
  logic [31:0] EX_store_data;
  logic [4:0]  EX_rd;
  logic        EX_we;
  logic        EX_mem_rd;
  logic        EX_mem_wr;
  logic [2:0]  EX_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] MEM_data_mem;
  logic [4:0]  MEM_rd;
  logic        MEM_we;
  logic        MEM_stall;
  logic        MEM_misaligned;

  int vectors = 0;
  int miscompares = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage_access dut (
    .clk(clk), .rst(rst),
    .EX_valid(EX_valid), .EX_alu_out(EX_alu_out), .EX_store_data(EX_store_data),
    .EX_rd(EX_rd), .EX_we(EX_we), .EX_mem_rd(EX_mem_rd), .EX_mem_wr(EX_mem_wr),
    .EX_funct3(EX_funct3),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MEM_data_mem(MEM_data_mem), .MEM_rd(MEM_rd), .MEM_we(MEM_we),
    .MEM_stall(MEM_stall), .MEM_misaligned(MEM_misaligned)
  );

  task step;
    @(posedge clk);
    #1;
  endtask

  task clear_ex;
    EX_valid = 0; EX_alu_out = 0; EX_store_data = 0; EX_rd = 0;
    EX_we = 0; EX_mem_rd = 0; EX_mem_wr = 0; EX_funct3 = 0;
  endtask

  task set_ex(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd, input logic we,
              input logic ld, input logic st, input logic [2:0] f3);
    EX_valid = 1; EX_alu_out = a; EX_store_data = sd; EX_rd = rd;
    EX_we = we; EX_mem_rd = ld; EX_mem_wr = st; EX_funct3 = f3;
  endtask

  task test_reset;
    rst = 0; clear_ex(); dmem_ack = 0; dmem_rdata = 0;
    step(); step(); #1;
    vectors++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== 70'd0) begin
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h wstrb=%b expected all 0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
      miscompares++;
    end
    vectors++;
    if ({MEM_stall, MEM_misaligned, MEM_we, MEM_rd, MEM_data_mem} !== 40'd0) begin
      $display("FAIL reset_mem: got stall=%b mis=%b we=%b rd=%0d data=%h expected all 0",
               MEM_stall, MEM_misaligned, MEM_we, MEM_rd, MEM_data_mem);
      miscompares++;
    end
    rst = 1;
  endtask

  task test_alu_pass;
    step();
    set_ex(32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    dmem_ack = 1;  // stray ack in IDLE must be ignored
    #1;
    vectors++;
    if ({MEM_data_mem, MEM_rd, MEM_we, MEM_stall, MEM_misaligned} !== {32'h1234_5678, 5'd5, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL alu_pass: got data=%h rd=%0d we=%b stall=%b mis=%b expected 12345678/5/1/0/0",
               MEM_data_mem, MEM_rd, MEM_we, MEM_stall, MEM_misaligned);
      miscompares++;
    end
    step(); #1;
    vectors++;
    if ({dmem_req, MEM_stall} !== 2'b00) begin
      $display("FAIL alu_no_req: got req=%b stall=%b expected 0/0", dmem_req, MEM_stall);
      miscompares++;
    end
    dmem_ack = 0; clear_ex();
  endtask

  task test_lb;
    stall_cnt = 0;
    step();
    set_ex(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000);
    #1;
    if (MEM_stall) stall_cnt++;
    vectors++;
    if ({MEM_stall, MEM_we, dmem_req} !== 3'b100) begin
      $display("FAIL lb_idle: got stall=%b we=%b req=%b expected 1/0/0", MEM_stall, MEM_we, dmem_req);
      miscompares++;
    end
    step();
    dmem_ack = 1; dmem_rdata = 32'h80FF_0000;
    #1;
    if (MEM_stall) stall_cnt++;
    vectors++;
    if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr, MEM_we} !== {1'b1, 1'b0, 4'b0000, 32'h0000_0100, 1'b0}) begin
      $display("FAIL lb_req: got req=%b we=%b wstrb=%b addr=%h mem_we=%b expected 1/0/0000/00000100/0",
               dmem_req, dmem_we, dmem_wstrb, dmem_addr, MEM_we);
      miscompares++;
    end
    step();
    dmem_ack = 0; dmem_rdata = 0; clear_ex();
    #1;
    if (MEM_stall) stall_cnt++;
    vectors++;
    if ({MEM_data_mem, MEM_rd, MEM_we, dmem_req} !== {32'hFFFF_FF80, 5'd7, 1'b1, 1'b0}) begin
      $display("FAIL lb_done: got data=%h rd=%0d we=%b req=%b expected ffffff80/7/1/0",
               MEM_data_mem, MEM_rd, MEM_we, dmem_req);
      miscompares++;
    end
    vectors++;
    if (stall_cnt !== 2) begin
      $display("FAIL lb_stall_cycles: got %0d expected 2", stall_cnt);
      miscompares++;
    end
  endtask

  task test_lhu_wait;
    stall_cnt = 0;
    step();
    set_ex(32'h0000_0202, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b101);
    #1;
    if (MEM_stall) stall_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      dmem_ack = (i == 3);
      dmem_rdata = (i == 3) ? 32'hBEEF_1234 : 32'h0;
      #1;
      if (MEM_stall) stall_cnt++;
      vectors++;
      if ({dmem_req, dmem_we, dmem_wstrb, dmem_addr} !== {1'b1, 1'b0, 4'b0000, 32'h0000_0200}) begin
        $display("FAIL lhu_req_hold[%0d]: got req=%b we=%b wstrb=%b addr=%h expected 1/0/0000/00000200",
                 i, dmem_req, dmem_we, dmem_wstrb, dmem_addr);
        miscompares++;
      end
    end
    step();
    dmem_ack = 0; dmem_rdata = 0; clear_ex();
    #1;
    if (MEM_stall) stall_cnt++;
    vectors++;
    if ({MEM_data_mem, MEM_rd, MEM_we} !== {32'h0000_BEEF, 5'd9, 1'b1}) begin
      $display("FAIL lhu_done: got data=%h rd=%0d we=%b expected 0000beef/9/1", MEM_data_mem, MEM_rd, MEM_we);
      miscompares++;
    end
    vectors++;
    if (stall_cnt !== 5) begin
      $display("FAIL lhu_stall_cycles: got %0d expected 5", stall_cnt);
      miscompares++;
    end
  endtask

  task test_sb;
    step();
    set_ex(32'h0000_0301, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      dmem_ack = (i == 2);
      #1;
      vectors++;
      if ({dmem_req, dmem_we, dmem_wdata, dmem_wstrb, dmem_addr, MEM_stall} !==
          {1'b1, 1'b1, 32'hDDDD_DDDD, 4'b0010, 32'h0000_0300, 1'b1}) begin
        $display("FAIL sb_req[%0d]: got req=%b we=%b wdata=%h wstrb=%b addr=%h stall=%b expected 1/1/dddddddd/0010/00000300/1",
                 i, dmem_req, dmem_we, dmem_wdata, dmem_wstrb, dmem_addr, MEM_stall);
        miscompares++;
      end
    end
    step();
    dmem_ack = 0; clear_ex();
    #1;
    vectors++;
    if ({MEM_we, MEM_data_mem, MEM_stall, dmem_req} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      $display("FAIL sb_done: got we=%b data=%h stall=%b req=%b expected 0/00000000/0/0",
               MEM_we, MEM_data_mem, MEM_stall, dmem_req);
      miscompares++;
    end
  endtask

  task test_misaligned;
    step();
    set_ex(32'h0000_0402, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010);  // LW misaligned
    #1;
    vectors++;
    if ({MEM_misaligned, MEM_stall, MEM_we, dmem_req} !== 4'b1000) begin
      $display("FAIL lw_misaligned: got mis=%b stall=%b we=%b req=%b expected 1/0/0/0",
               MEM_misaligned, MEM_stall, MEM_we, dmem_req);
      miscompares++;
    end
    step();
    set_ex(32'h0000_0405, 32'h1111_2222, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001);  // SH misaligned
    #1;
    vectors++;
    if ({MEM_misaligned, MEM_stall, MEM_we, dmem_req} !== 4'b1000) begin
      $display("FAIL sh_misaligned: got mis=%b stall=%b we=%b req=%b expected 1/0/0/0",
               MEM_misaligned, MEM_stall, MEM_we, dmem_req);
      miscompares++;
    end
    step();
    set_ex(32'h0000_0400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b011);  // illegal load funct3
    #1;
    vectors++;
    if ({MEM_misaligned, MEM_stall, MEM_we, dmem_req} !== 4'b1000) begin
      $display("FAIL illegal_f3: got mis=%b stall=%b we=%b req=%b expected 1/0/0/0",
               MEM_misaligned, MEM_stall, MEM_we, dmem_req);
      miscompares++;
    end
    step();
    set_ex(32'h0000_0400, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 3'b010);  // load and store together
    #1;
    vectors++;
    if ({MEM_misaligned, MEM_stall, MEM_we, dmem_req} !== 4'b1000) begin
      $display("FAIL rd_and_wr: got mis=%b stall=%b we=%b req=%b expected 1/0/0/0",
               MEM_misaligned, MEM_stall, MEM_we, dmem_req);
      miscompares++;
    end
    step();
    clear_ex();
    #1;
    vectors++;
    if ({MEM_misaligned, MEM_stall, dmem_req} !== 3'b000) begin
      $display("FAIL fault_after: got mis=%b stall=%b req=%b expected 0/0/0", MEM_misaligned, MEM_stall, dmem_req);
      miscompares++;
    end
  endtask

  task test_reset_in_req;
    step();
    set_ex(32'h0000_0500, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010);
    step(); #1;
    vectors++;
    if (dmem_req !== 1'b1) begin
      $display("FAIL rstreq_req: got req=%b expected 1", dmem_req);
      miscompares++;
    end
    rst = 0; clear_ex();
    step(); #1;
    vectors++;
    if ({dmem_req, MEM_stall, MEM_we} !== 3'b000) begin
      $display("FAIL rstreq_after_reset: got req=%b stall=%b we=%b expected 0/0/0", dmem_req, MEM_stall, MEM_we);
      miscompares++;
    end
    rst = 1;
    step();
    dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    #1;
    vectors++;
    if ({dmem_req, MEM_stall, MEM_we, MEM_rd, MEM_data_mem} !== 40'd0) begin
      $display("FAIL rstreq_late_ack: got req=%b stall=%b we=%b rd=%0d data=%h expected all 0",
               dmem_req, MEM_stall, MEM_we, MEM_rd, MEM_data_mem);
      miscompares++;
    end
  endtask

  task test_back_to_back;
    step();
    set_ex(32'h0000_0600, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010);  // LW
    step();
    dmem_ack = 1; dmem_rdata = 32'h1122_3344;
    #1;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    set_ex(32'h0000_0601, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b100);  // LBU presented during DONE
    #1;
    vectors++;
    if ({MEM_data_mem, MEM_rd, MEM_we, MEM_stall} !== {32'h1122_3344, 5'd10, 1'b1, 1'b0}) begin
      $display("FAIL b2b_first_done: got data=%h rd=%0d we=%b stall=%b expected 11223344/10/1/0",
               MEM_data_mem, MEM_rd, MEM_we, MEM_stall);
      miscompares++;
    end
    step(); #1;
    vectors++;
    if ({MEM_stall, MEM_we, dmem_req} !== 3'b100) begin
      $display("FAIL b2b_second_idle: got stall=%b we=%b req=%b expected 1/0/0", MEM_stall, MEM_we, dmem_req);
      miscompares++;
    end
    step();
    dmem_ack = 1; dmem_rdata = 32'h0000_A500;
    #1;
    vectors++;
    if ({dmem_req, dmem_addr} !== {1'b1, 32'h0000_0600}) begin
      $display("FAIL b2b_second_req: got req=%b addr=%h expected 1/00000600", dmem_req, dmem_addr);
      miscompares++;
    end
    step();
    dmem_ack = 0; dmem_rdata = 0; clear_ex();
    #1;
    vectors++;
    if ({MEM_data_mem, MEM_rd, MEM_we} !== {32'h0000_00A5, 5'd11, 1'b1}) begin
      $display("FAIL b2b_second_done: got data=%h rd=%0d we=%b expected 000000a5/11/1",
               MEM_data_mem, MEM_rd, MEM_we);
      miscompares++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_pass();
    test_lb();
    test_lhu_wait();
    test_sb();
    test_misaligned();
    test_reset_in_req();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
